fpu_divsqrt_iter: RTL and testbench

//  Multi-cycle iterative floating-point divide / square-root unit, one result per

---
 rtl/fpu_divsqrt_iter_if.sv | 31 +++
 rtl/fpu_divsqrt_iter.sv | 220 ++++++++++++++++++++++
 tb/tb_fpu_divsqrt_iter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_divsqrt_iter_if.sv
// Issue / result port of the iterative FP divide / square-root unit.
// The issuer uses the master modport, the unit the slave modport.
interface fpu_divsqrt_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int FMT_W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       operation;
    logic [FMT_W-1:0] op_a;
    logic [FMT_W-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [FMT_W-1:0] result;
    logic             overflow;
    logic             underflow;
    logic             div_zero;
    logic             root_error;

    modport master (
        output in_valid, operation, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, div_zero, root_error
    );

    modport slave (
        input  in_valid, operation, op_a, op_b, out_ready,
        output in_ready, out_valid, result, overflow, underflow, div_zero, root_error
    );
endinterface

// File: rtl/fpu_divsqrt_iter.sv
// Multi-cycle FP divide / square root: radix-2 non-restoring recurrence producing
// MAN_W+3 quotient/root bits (hidden + fraction + guard + round), then RNE rounding.
module fpu_divsqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    fpu_divsqrt_iter_if.slave io
);
    localparam int FMT_W = 1 + EXP_W + MAN_W;
    localparam int N     = MAN_W + 3;
    localparam int RW    = N + 4;
    localparam int SE_W  = EXP_W + 3;
    localparam int CNT_W = $clog2(N);

    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;

    localparam logic signed [SE_W-1:0] BIAS_S = SE_W'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [SE_W-1:0] EMAX_S = SE_W'(2 ** EXP_W - 1);
    localparam logic signed [SE_W-1:0] ONE_S  = SE_W'(1);
    localparam logic signed [SE_W-1:0] ZERO_S = '0;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(N - 1);

    localparam logic [FMT_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [FMT_W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [2:0]             op_reg;
    logic [FMT_W-1:0]       a_reg, b_reg, result_reg;
    logic                   special_reg, sign_reg;
    logic signed [SE_W-1:0] exp_reg;
    logic [MAN_W:0]         d_reg;
    logic [2*N-1:0]         rad_reg;
    logic signed [RW-1:0]   rem_reg;
    logic [N-1:0]           q_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   ovf_reg, unf_reg, dz_reg, re_reg;

    // Operand fields and classification (exp==0 means zero: no denormals)
    logic                   sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W:0]         ma, mb;

    assign sa     = a_reg[FMT_W-1];
    assign sb     = b_reg[FMT_W-1];
    assign ea     = a_reg[FMT_W-2 -: EXP_W];
    assign eb     = b_reg[FMT_W-2 -: EXP_W];
    assign ma     = {1'b1, a_reg[MAN_W-1:0]};
    assign mb     = {1'b1, b_reg[MAN_W-1:0]};
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (a_reg[MAN_W-1:0] == '0);
    assign b_inf  = (eb == '1) && (b_reg[MAN_W-1:0] == '0);
    assign a_nan  = (ea == '1) && (a_reg[MAN_W-1:0] != '0);
    assign b_nan  = (eb == '1) && (b_reg[MAN_W-1:0] != '0);

    logic                   spec_hit, spec_dz, spec_re;
    logic [FMT_W-1:0]       spec_res;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = QNAN;
        spec_dz  = 1'b0;
        spec_re  = 1'b0;
        if (op_reg != OP_DIV && op_reg != OP_SQRT) begin
            spec_re = 1'b1;
        end else if (op_reg == OP_SQRT) begin
            if (a_nan)       spec_res = QNAN;
            else if (a_zero) spec_res = {sa, {(FMT_W-1){1'b0}}};
            else if (sa)     spec_re  = 1'b1;
            else if (a_inf)  spec_res = {1'b0, INF_MAG};
            else             spec_hit = 1'b0;
        end else begin
            if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
                spec_res = QNAN;
            end else if (b_zero) begin
                spec_res = {sa ^ sb, INF_MAG};
                spec_dz  = 1'b1;
            end else if (a_inf)           spec_res = {sa ^ sb, INF_MAG};
            else if (b_inf || a_zero)     spec_res = {sa ^ sb, {(FMT_W-1){1'b0}}};
            else                          spec_hit = 1'b0;
        end
    end

    // Exponent setup; an odd sqrt exponent is made even by doubling the radicand
    logic signed [SE_W-1:0] e_div, e_unb, e_sq;
    logic [2*N-1:0]         rad_init;

    always_comb begin
        e_div    = $signed({3'b000, ea}) - $signed({3'b000, eb}) + BIAS_S;
        e_unb    = $signed({3'b000, ea}) - BIAS_S;
        e_sq     = ((e_unb - $signed({{(SE_W-1){1'b0}}, e_unb[0]})) >>> 1) + BIAS_S;
        rad_init = e_unb[0] ? {ma, 1'b0, {(MAN_W+4){1'b0}}} : {1'b0, ma, {(MAN_W+4){1'b0}}};
    end

    // One recurrence step: divide keeps w = partial remainder - d, sqrt is Li/Chu
    logic signed [RW-1:0]   d_ext, div_w2, sq_r4, rem_step, rem_fix;
    logic                   q_bit, sticky;

    always_comb begin
        d_ext  = $signed({{(RW-MAN_W-1){1'b0}}, d_reg});
        div_w2 = rem_reg <<< 1;
        sq_r4  = (rem_reg <<< 2) + $signed({{(RW-2){1'b0}}, rad_reg[2*N-1 -: 2]});
        if (op_reg == OP_SQRT) begin
            rem_step = rem_reg[RW-1] ? sq_r4 + $signed({2'b00, q_reg, 2'b11})
                                     : sq_r4 - $signed({2'b00, q_reg, 2'b01});
            q_bit    = ~rem_step[RW-1];
            rem_fix  = rem_reg[RW-1] ? rem_reg + $signed({3'b000, q_reg, 1'b1}) : rem_reg;
        end else begin
            q_bit    = ~rem_reg[RW-1];
            rem_step = q_bit ? div_w2 - d_ext : div_w2 + d_ext;
            rem_fix  = rem_reg + d_ext;
        end
        sticky = |rem_fix;
    end

    // Normalise, round to nearest even, then range-check the biased exponent
    logic [N-1:0]           qn;
    logic signed [SE_W-1:0] en, er;
    logic [MAN_W+1:0]       mant_r;
    logic                   round_up, rnd_ovf, rnd_unf;
    logic [FMT_W-1:0]       rnd_res;

    always_comb begin
        qn       = q_reg[N-1] ? q_reg : {q_reg[N-2:0], 1'b0};
        en       = q_reg[N-1] ? exp_reg : exp_reg - ONE_S;
        round_up = qn[1] & (qn[0] | sticky | qn[2]);
        mant_r   = {1'b0, qn[N-1:2]} + {{(MAN_W+1){1'b0}}, round_up};
        er       = en + $signed({{(SE_W-1){1'b0}}, mant_r[MAN_W+1]});
        rnd_ovf  = (er >= EMAX_S);
        rnd_unf  = !rnd_ovf && (er <= ZERO_S);
        // On mantissa carry-out the low MAN_W bits of mant_r are already zero
        if (rnd_ovf)      rnd_res = {sign_reg, INF_MAG};
        else if (rnd_unf) rnd_res = {sign_reg, {(FMT_W-1){1'b0}}};
        else              rnd_res = {sign_reg, er[EXP_W-1:0], mant_r[MAN_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Specials still pass through ROUND so both paths leave from the same stage
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (io.in_valid) state_next = S_UNPACK;
            S_UNPACK: state_next = spec_hit ? S_ROUND : S_ITER;
            S_ITER:   if (cnt_reg == CNT_LAST) state_next = S_ROUND;
            S_ROUND:  state_next = S_DONE;
            S_DONE:   if (io.out_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = (state_reg == S_IDLE);
        io.out_valid = (state_reg == S_DONE);
        io.result     = result_reg;
        io.overflow   = ovf_reg;
        io.underflow  = unf_reg;
        io.div_zero   = dz_reg;
        io.root_error = re_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg <= '0;  a_reg <= '0;  b_reg <= '0;  result_reg <= '0;
            special_reg <= 1'b0;  sign_reg <= 1'b0;  exp_reg <= '0;
            d_reg <= '0;  rad_reg <= '0;  rem_reg <= '0;  q_reg <= '0;  cnt_reg <= '0;
            ovf_reg <= 1'b0;  unf_reg <= 1'b0;  dz_reg <= 1'b0;  re_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: if (io.in_valid) begin
                    op_reg  <= io.operation;
                    a_reg   <= io.op_a;
                    b_reg   <= io.op_b;
                    ovf_reg <= 1'b0;  unf_reg <= 1'b0;  dz_reg <= 1'b0;  re_reg <= 1'b0;
                end
                S_UNPACK: begin
                    special_reg <= spec_hit;
                    cnt_reg     <= '0;
                    q_reg       <= '0;
                    d_reg       <= mb;
                    rad_reg     <= rad_init;
                    if (spec_hit) begin
                        result_reg <= spec_res;
                        dz_reg     <= spec_dz;
                        re_reg     <= spec_re;
                    end else if (op_reg == OP_SQRT) begin
                        sign_reg <= sa;
                        exp_reg  <= e_sq;
                        rem_reg  <= '0;
                    end else begin
                        sign_reg <= sa ^ sb;
                        exp_reg  <= e_div;
                        rem_reg  <= $signed({{(RW-MAN_W-1){1'b0}}, ma}) -
                                    $signed({{(RW-MAN_W-1){1'b0}}, mb});
                    end
                end
                S_ITER: begin
                    q_reg   <= {q_reg[N-2:0], q_bit};
                    rem_reg <= rem_step;
                    rad_reg <= rad_reg << 2;
                    cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
                end
                S_ROUND: if (!special_reg) begin
                    result_reg <= rnd_res;
                    ovf_reg    <= rnd_ovf;
                    unf_reg    <= rnd_unf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Bench for fpu_divsqrt_iter: single- and half-format instances, vector table with
// a result scoreboard, plus handshake-hold and mid-operation reset sequences.
module tb_fpu_divsqrt_iter;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;

    typedef struct {
        logic        half;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;   // {overflow, underflow, div_zero, root_error}
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_divsqrt_iter_if #(.EXP_W(8), .MAN_W(23)) if_s ();
    fpu_divsqrt_iter_if #(.EXP_W(5), .MAN_W(10)) if_h ();

    fpu_divsqrt_iter #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst(rst), .io(if_s));
    fpu_divsqrt_iter #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .io(if_h));

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t sb[$];
    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] dut_res(input logic half);
        return half ? {16'h0, if_h.result} : if_s.result;
    endfunction

    function automatic logic [31:0] dut_flags(input logic half);
        return half ? {28'h0, if_h.overflow, if_h.underflow, if_h.div_zero, if_h.root_error}
                    : {28'h0, if_s.overflow, if_s.underflow, if_s.div_zero, if_s.root_error};
    endfunction

    // {out_valid, in_ready} packed for compact handshake checks
    function automatic logic [31:0] dut_hs(input logic half);
        return half ? {30'h0, if_h.out_valid, if_h.in_ready} : {30'h0, if_s.out_valid, if_s.in_ready};
    endfunction

    task automatic drive(input logic half, input logic valid, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (half) begin
            if_h.in_valid = valid; if_h.operation = op; if_h.op_a = a[15:0]; if_h.op_b = b[15:0];
        end else begin
            if_s.in_valid = valid; if_s.operation = op; if_s.op_a = a; if_s.op_b = b;
        end
    endtask

    task automatic set_ready(input logic half, input logic rdy);
        if (half) if_h.out_ready = rdy;
        else      if_s.out_ready = rdy;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input vec_t v, input string tag, output bit ok);
        int w = 0;
        while (dut_hs(v.half) != 32'd1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 50);
        if (!ok) begin
            timeout({tag, " in_ready"});
            return;
        end
        drive(v.half, 1'b1, v.op, v.a, v.b);
        @(posedge clk);
        sb.push_back(v);
        @(negedge clk);
        // garbage on the inputs while busy must not disturb the operation
        drive(v.half, 1'b0, 3'($urandom_range(7)), $urandom, $urandom);
    endtask

    task automatic wait_out(input logic half, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (dut_hs(half) == 32'd2) got = 1'b1;
        end
    endtask

    task automatic compare_out(input logic half, input int lat, input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            timeout({tag, " scoreboard empty"});
            return;
        end
        e = sb.pop_front();
        check({tag, " result"}, dut_res(half), e.res);
        check({tag, " flags"}, dut_flags(half), {28'h0, e.flags});
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        $display("%s op=%b a=%h b=%h -> result=%h flags=%b latency=%0d",
                 tag, e.op, e.a, e.b, dut_res(half), dut_flags(half), lat);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        bit ok, got;
        int lat;
        issue(v, tag, ok);
        if (!ok) return;
        wait_out(v.half, lat, got);
        if (!got) begin
            timeout({tag, " out_valid"});
            return;
        end
        compare_out(v.half, lat, tag);
        set_ready(v.half, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ready(v.half, 1'b0);
        check({tag, " back to idle"}, dut_hs(v.half), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok, got;
        int   lat, rises;
        vec_t v;

        vecs[0]  = '{1'b0, OP_DIV,  32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28};
        vecs[1]  = '{1'b0, OP_SQRT, 32'h40800000, 32'h0,        32'h40000000, 4'b0000, 28};
        vecs[2]  = '{1'b0, OP_SQRT, 32'h40000000, 32'h0,        32'h3FB504F3, 4'b0000, 28};
        vecs[3]  = '{1'b0, OP_DIV,  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 2};
        vecs[4]  = '{1'b0, OP_SQRT, 32'hBF800000, 32'h0,        32'h7FC00000, 4'b0001, 2};
        vecs[5]  = '{1'b0, OP_DIV,  32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0000, 2};
        vecs[6]  = '{1'b0, OP_DIV,  32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b1000, 28};
        vecs[7]  = '{1'b0, OP_DIV,  32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 28};
        vecs[8]  = '{1'b0, OP_DIV,  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28};
        vecs[9]  = '{1'b0, OP_DIV,  32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000, 28};
        vecs[10] = '{1'b0, 3'b000,  32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b0001, 2};
        vecs[11] = '{1'b0, OP_SQRT, 32'h80000000, 32'h0,        32'h80000000, 4'b0000, 2};
        vecs[12] = '{1'b0, OP_DIV,  32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 2};
        vecs[13] = '{1'b0, OP_DIV,  32'hBF800000, 32'h7F800000, 32'h80000000, 4'b0000, 2};
        vecs[14] = '{1'b0, OP_SQRT, 32'h7F800000, 32'h0,        32'h7F800000, 4'b0000, 2};
        vecs[15] = '{1'b0, OP_DIV,  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 2};
        vecs[16] = '{1'b0, OP_SQRT, 32'h3F800000, 32'h0,        32'h3F800000, 4'b0000, 28};
        vecs[17] = '{1'b1, OP_DIV,  32'h00003C00, 32'h00004200, 32'h00003555, 4'b0000, 15};
        vecs[18] = '{1'b1, OP_SQRT, 32'h00004400, 32'h0,        32'h00004000, 4'b0000, 15};

        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        set_ready(1'b0, 1'b0);
        set_ready(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        for (int h = 0; h < 2; h++) begin
            check($sformatf("reset%0d handshake", h), dut_hs(h[0]), 32'd1);
            check($sformatf("reset%0d result", h), dut_res(h[0]), 32'h0);
            check($sformatf("reset%0d flags", h), dut_flags(h[0]), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) run_op(vecs[i], $sformatf("v%0d", i));

        // Hold the result for 10 cycles while a new request is presented
        v = vecs[8];
        issue(v, "hold", ok);
        if (ok) begin
            wait_out(1'b0, lat, got);
            if (!got) timeout("hold out_valid");
            else compare_out(1'b0, lat, "hold");
            drive(1'b0, 1'b1, OP_SQRT, 32'hBF800000, 32'h0);
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("hold%0d result", k), dut_res(1'b0), v.res);
                check($sformatf("hold%0d handshake", k), dut_hs(1'b0), 32'd2);
            end
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            set_ready(1'b0, 1'b1);
            @(posedge clk);
            @(negedge clk);
            set_ready(1'b0, 1'b0);
            check("hold release", dut_hs(1'b0), 32'd1);
            check("hold no stray op", 32'(sb.size()), 32'd0);
        end
        run_op(vecs[1], "after_hold");

        // Reset during the fifth iteration cycle aborts the operation
        issue(vecs[0], "abort", ok);
        if (ok) begin
            repeat (5) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
            check("abort handshake", dut_hs(1'b0), 32'd1);
            check("abort result", dut_res(1'b0), 32'h0);
            check("abort flags", dut_flags(1'b0), 32'h0);
            rises = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (if_s.out_valid !== 1'b0) rises++;
            end
            check("abort out_valid rises", 32'(rises), 32'd0);
            $display("abort: reset at iteration cycle 5, out_valid rises=%0d", rises);
        end
        run_op(vecs[2], "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
